mem_line_bridge: RTL
====================

# mem_line_bridge

Downstream neighbour of the Elpis core's last-level memory port. Accepts one 128-bit cache-line request at a time from the core's arbiter (`is_mem_req` / `is_memory_we` / `mem_addr_out` / `mem_data_out`). Serialises each request into four 32-bit Wishbone classic single-beat transfers. Returns the assembled line with a one-cycle ready pulse that drives the core's `is_mem_ready` and `data_from_mem`.

## Interface

Parameters:
- `BASE_ADDR`, 32'h3000_0000: Wishbone byte address that maps to physical line address 0.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `mem_req`  in  1  line request from core (`is_mem_req`).
- `mem_we`  in  1  1 = line write, 0 = line read (`is_memory_we`).
- `mem_addr`  in  20  physical byte address of the line; bits [3:0] are ignored and treated as 0.
- `mem_wdata`  in  128  write line; word k = bits [32k+31:32k].
- `mem_req_reset`  in  1  core cancels the outstanding request (`is_mem_req_reset`).
- `mem_rdata`  out  128  read line returned to core (`data_from_mem`).
- `mem_ready`  out  1  one-cycle completion pulse (`is_mem_ready`).
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone master controls.
- `wb_sel_o`  out  4  byte selects; always 4'hF while `wb_stb_o` = 1, otherwise 0.
- `wb_adr_o`  out  32  beat address.
- `wb_dat_o`  out  32  beat write data.
- `wb_dat_i`  in  32  beat read data.
- `wb_ack_i`  in  1  beat acknowledge.

## Operation

- State machine has three states: IDLE, BUS, RELEASE. A 2-bit beat index k and a `cancel` flag are kept alongside it.
- IDLE, on `mem_req`=1 and `mem_req_reset`=0:
  - latch `mem_addr[19:4]`, `mem_we` and `mem_wdata`;
  - set k=0 and `cancel`=0;
  - go to BUS.
- BUS:
  - `wb_cyc_o`=`wb_stb_o`=1 and `wb_we_o`=latched we;
  - `wb_adr_o` = `BASE_ADDR` + {12'b0, line[19:4], k, 2'b00}, with 32-bit addition and wrap discarded;
  - `wb_dat_o` = latched word k on writes, 0 on reads.
- Each sampled `wb_ack_i`=1 in BUS completes beat k:
  - on reads, `wb_dat_i` is captured into `mem_rdata` word k;
  - then k increments.
- On the ack of beat 3, the FSM goes to RELEASE. In the same edge `mem_ready` is set to 1 for exactly one cycle, unless `cancel`=1.
- `mem_req_reset`=1 at any edge in BUS sets `cancel`. The bus sequence is never truncated, so writes are never torn. All four beats still complete, and no `mem_ready` pulse is issued.
- RELEASE: the FSM waits for `mem_req`=0 or `mem_req_reset`=1, then returns to IDLE. This prevents a held request from being serviced twice.
- `mem_rdata` holds its value until the next read beat overwrites it. Write transactions never modify it.
- Asynchronous reset:
  - state goes to IDLE, k=0, `cancel`=0;
  - all outputs go to 0, including `mem_rdata`=128'h0 and `mem_ready`=0;
  - the Wishbone strobes drop immediately, without waiting for a clock edge;
  - an in-flight beat is abandoned.

## Timing

- Take cycle N as the cycle in which `mem_req` is sampled high in IDLE.
- Beat 0 is presented from cycle N+1. Wishbone outputs are registered.
- Each beat occupies 1+W cycles, where W is the number of wait cycles before `wb_ack_i`. A combinational ack in the first stb cycle gives W=0.
- The next beat is presented in the cycle after the previous ack, with `wb_cyc_o` and `wb_stb_o` held continuously high.
- `mem_ready` is high in cycle N+1+Σ(1+W_k), which is N+5 for a zero-wait slave. `mem_rdata` is valid in that same cycle.
- `wb_cyc_o` and `wb_stb_o` are low in the `mem_ready` cycle.
- Minimum gap between two transactions is 1 cycle: RELEASE to IDLE, then a new accept.
- `wb_ack_i` outside BUS is ignored.

## Test plan

- Zero-wait read, `mem_addr`=20'h00120, slave words 11111111/22222222/33333333/44444444:
  - `wb_adr_o` sequence 3000_0120, 0124, 0128, 012C;
  - `mem_ready` high only at N+5;
  - `mem_rdata`=128'h44444444_33333333_22222222_11111111.
- Write with 2 wait cycles per beat, `mem_wdata`=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA:
  - four beats with `wb_we_o`=1 and `wb_sel_o`=F;
  - `wb_dat_o` sequence AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD;
  - `mem_ready` at N+13;
  - `mem_rdata` unchanged.
- Unaligned read at `mem_addr`=20'h00127: addresses identical to the aligned case (3000_0120 to 3000_012C).
- `mem_req_reset` pulsed during beat 1 of a read:
  - all four beats complete, and no `mem_ready` pulse is issued;
  - the FSM is back in IDLE;
  - a following read at 20'h00200 completes normally.
- `mem_req` held high for 20 cycles after `mem_ready`: exactly one Wishbone transaction occurs. A second transaction starts only after `mem_req` drops for at least one cycle and is re-asserted.
- `rst`=0 asserted mid-beat 2:
  - `wb_cyc_o`, `wb_stb_o` and `mem_ready` go to 0 before the next clock edge;
  - `mem_rdata`=0;
  - after release, a fresh read completes with correct data.

Source files
------------

// File: rtl/mem_line_bridge.sv
// Bridges one 128-bit cache-line request into four 32-bit Wishbone classic beats.
// The assembled line is returned with a single-cycle ready pulse.
module mem_line_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_req,
    input  logic         mem_we,
    input  logic [19:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    input  logic         mem_req_reset,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    output logic         wb_we_o,
    output logic [3:0]   wb_sel_o,
    output logic [31:0]  wb_adr_o,
    output logic [31:0]  wb_dat_o,
    input  logic [31:0]  wb_dat_i,
    input  logic         wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         state_r;
    logic [1:0]     beat_r;
    logic           cancel_r;
    logic           we_r;
    logic [19:0]    line_r;
    logic [127:0]   wdata_r;
    logic [1:0]     beat_nxt_s;

    // line_addr carries zeros in [3:0], so adding the beat offset equals concatenating it
    function automatic logic [31:0] beat_addr(input logic [19:0] line_addr, input logic [1:0] k);
        return BASE_ADDR + {12'h000, line_addr} + {28'h000_0000, k, 2'b00};
    endfunction

    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] k);
        return line[{k, 5'b00000} +: 32];
    endfunction

    assign beat_nxt_s = beat_r + 2'd1;

    // Line FSM; all Wishbone and core-side outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            beat_r    <= 2'd0;
            cancel_r  <= 1'b0;
            we_r      <= 1'b0;
            line_r    <= 20'h00000;
            wdata_r   <= 128'h0;
            mem_rdata <= 128'h0;
            mem_ready <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            wb_adr_o  <= 32'h0000_0000;
            wb_dat_o  <= 32'h0000_0000;
        end else begin
            mem_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_req && !mem_req_reset) begin
                        line_r   <= mem_addr & 20'hFFFF0;
                        we_r     <= mem_we;
                        wdata_r  <= mem_wdata;
                        beat_r   <= 2'd0;
                        cancel_r <= 1'b0;
                        state_r  <= ST_BUS;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= mem_we;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= beat_addr(mem_addr & 20'hFFFF0, 2'd0);
                        wb_dat_o <= mem_we ? mem_wdata[31:0] : 32'h0000_0000;
                    end
                end
                ST_BUS: begin
                    // a cancel only suppresses the ready pulse; the beats always finish
                    if (mem_req_reset) begin
                        cancel_r <= 1'b1;
                    end
                    if (wb_ack_i) begin
                        if (!we_r) begin
                            mem_rdata[{beat_r, 5'b00000} +: 32] <= wb_dat_i;
                        end
                        if (beat_r == 2'd3) begin
                            state_r   <= ST_RELEASE;
                            beat_r    <= 2'd0;
                            mem_ready <= !(cancel_r || mem_req_reset);
                            wb_cyc_o  <= 1'b0;
                            wb_stb_o  <= 1'b0;
                            wb_we_o   <= 1'b0;
                            wb_sel_o  <= 4'h0;
                            wb_adr_o  <= 32'h0000_0000;
                            wb_dat_o  <= 32'h0000_0000;
                        end else begin
                            beat_r   <= beat_nxt_s;
                            wb_adr_o <= beat_addr(line_r, beat_nxt_s);
                            wb_dat_o <= we_r ? line_word(wdata_r, beat_nxt_s) : 32'h0000_0000;
                        end
                    end
                end
                ST_RELEASE: begin
                    // a request still held from the finished transaction must not restart it
                    if (!mem_req || mem_req_reset) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    beat_r   <= 2'd0;
                    cancel_r <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    wb_sel_o <= 4'h0;
                    wb_adr_o <= 32'h0000_0000;
                    wb_dat_o <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule
